fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch front end with a small register-file code
// memory, a single output slot, branch redirects and a sticky alignment fault.
//
// Output handshake: inst_valid/inst/inst_pc form a valid/ready source. Once
// inst_valid is high the payload holds stable until an edge where inst_ready
// is also high (a handshake); the slot is free for a new fetch on any edge
// where inst_valid is low or a handshake happens.
module fetch_unit #(
  parameter int                 DATA_W   = 32,
  parameter int                 DEPTH    = 32,
  parameter int                 PC_W     = 32,
  parameter logic [PC_W-1:0]    RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       run,
  input  logic                       prog_we,
  input  logic [$clog2(DEPTH)-1:0]   prog_addr,
  input  logic [DATA_W-1:0]          prog_data,
  input  logic                       redirect_valid,
  input  logic [PC_W-1:0]            redirect_target,
  input  logic                       inst_ready,
  output logic                       inst_valid,
  output logic [DATA_W-1:0]          inst,
  output logic [PC_W-1:0]            inst_pc,
  output logic                       fault,
  output logic [15:0]                fetch_count,
  output logic [1:0]                 state
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    S_HALT  = 2'd0,
    S_FETCH = 2'd1,
    S_FAULT = 2'd2
  } state_t;

  // Code memory: written synchronously, read combinationally, never reset.
  logic [DATA_W-1:0] r_mem [DEPTH];

  state_t            r_state;
  state_t            w_state_nxt;
  logic [PC_W-1:0]   r_pc;
  logic [PC_W-1:0]   w_pc_nxt;
  logic              r_valid;
  logic              w_valid_nxt;
  logic [DATA_W-1:0] r_inst;
  logic [DATA_W-1:0] w_inst_nxt;
  logic [PC_W-1:0]   r_inst_pc;
  logic [PC_W-1:0]   w_inst_pc_nxt;
  logic              r_fault;
  logic              w_fault_nxt;
  logic [15:0]       r_count;

  logic              w_handshake;
  logic              w_slot_free;
  logic              w_redir_ok;
  logic              w_redir_bad;
  logic [AW-1:0]     w_rd_idx;
  logic [DATA_W-1:0] w_rd_data;

  assign w_handshake = r_valid & inst_ready;
  assign w_slot_free = ~r_valid | inst_ready;
  assign w_redir_ok  = redirect_valid & (redirect_target[1:0] == 2'b00);
  assign w_redir_bad = redirect_valid & (redirect_target[1:0] != 2'b00);

  // Upper PC bits are ignored so fetch addresses wrap over the memory.
  assign w_rd_idx  = r_pc[AW+1:2];
  // Read sees the pre-write contents; a same-edge write shows up next cycle.
  assign w_rd_data = r_mem[w_rd_idx];

  // Code memory write port, honoured in every state including FAULT.
  always_ff @(posedge clk) begin
    if (prog_we) begin
      r_mem[prog_addr] <= prog_data;
    end
  end

  // Next-state and next-datapath decision for the fetch FSM.
  always_comb begin
    w_state_nxt   = r_state;
    w_pc_nxt      = r_pc;
    w_valid_nxt   = r_valid & ~w_handshake;
    w_inst_nxt    = r_inst;
    w_inst_pc_nxt = r_inst_pc;
    w_fault_nxt   = r_fault;

    unique case (r_state)
      S_HALT: begin
        if (w_redir_bad) begin
          w_state_nxt = S_FAULT;
          w_fault_nxt = 1'b1;
          w_valid_nxt = 1'b0;
        end else if (w_redir_ok) begin
          // Redirect while halted only moves the PC; stay halted.
          w_pc_nxt    = redirect_target;
          w_valid_nxt = 1'b0;
        end else if (run) begin
          // First fetch happens on the edge after entering FETCH.
          w_state_nxt = S_FETCH;
        end
      end

      S_FETCH: begin
        if (w_redir_bad) begin
          w_state_nxt = S_FAULT;
          w_fault_nxt = 1'b1;
          w_valid_nxt = 1'b0;
        end else if (w_redir_ok) begin
          // Flush the slot; the target is fetched one edge later.
          w_pc_nxt    = redirect_target;
          w_valid_nxt = 1'b0;
          if (!run) begin
            w_state_nxt = S_HALT;
          end
        end else if (!run) begin
          // Stop issuing; any pending instruction waits to be consumed.
          w_state_nxt = S_HALT;
        end else if (w_slot_free) begin
          w_valid_nxt   = 1'b1;
          w_inst_nxt    = w_rd_data;
          w_inst_pc_nxt = r_pc;
          w_pc_nxt      = r_pc + PC_W'(4);
        end
      end

      S_FAULT: begin
        // Terminal until reset: nothing is presented.
        w_valid_nxt = 1'b0;
      end

      default: begin
        w_state_nxt = S_HALT;
        w_valid_nxt = 1'b0;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_HALT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // PC, output slot and sticky fault registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc      <= RESET_PC;
      r_valid   <= 1'b0;
      r_inst    <= '0;
      r_inst_pc <= '0;
      r_fault   <= 1'b0;
    end else begin
      r_pc      <= w_pc_nxt;
      r_valid   <= w_valid_nxt;
      r_inst    <= w_inst_nxt;
      r_inst_pc <= w_inst_pc_nxt;
      r_fault   <= w_fault_nxt;
    end
  end

  // Completed-handshake counter, wraps at 16 bits; counts even when flushed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (w_handshake) begin
      r_count <= r_count + 16'd1;
    end
  end

  assign inst_valid  = r_valid;
  assign inst        = r_inst;
  assign inst_pc     = r_inst_pc;
  assign fault       = r_fault;
  assign fetch_count = r_count;
  assign state       = r_state;

endmodule
